// File: rtl/uart_rx.sv
// UART receiver: 8N1 serial frames to a valid/ready byte stream with framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit after bit 7 and the parity_err output.
module uart_rx #(
    parameter int unsigned CLK_DIV = 104,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);

    if (CLK_DIV < 4) begin : g_bad_div
        $error("uart_rx: CLK_DIV must be >= 4");
    end
    if (CLK_DIV - 1 >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("uart_rx: CNT_W too narrow for CLK_DIV-1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_sr;
    logic [1:0]       r_sync;
    logic             r_deliver;
    logic             w_rx_s;
    logic             w_cnt_zero;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
`endif

    assign w_rx_s     = r_sync[1];
    assign w_cnt_zero = (r_cnt == '0);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Frame FSM, holding register and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_sr        <= 8'h00;
            r_deliver   <= 1'b0;
            data        <= 8'h00;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            r_deliver   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif

            if (valid && ready) begin
                valid <= 1'b0;
            end

            // A deliver wins over the consume-driven clear above.
            if (r_deliver) begin
                if (!valid || ready) begin
                    data  <= r_sr;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err <= r_par_bad;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                    end
                end

                S_START: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DATA;
                        r_bit   <= 3'd0;
                        r_cnt   <= CNT_FULL;
                    end
                end

                S_DATA: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_sr[r_bit] <= w_rx_s;
                        r_cnt       <= CNT_FULL;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Even parity: data ones plus parity bit must be even.
                        r_par_bad <= w_rx_s ^ (^r_sr);
                        r_state   <= S_STOP;
                        r_cnt     <= CNT_FULL;
                    end
                end
`endif

                S_STOP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_rx_s) begin
                        r_deliver <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        framing_err <= 1'b1;
                        r_state     <= S_BREAK;
                    end
                end

                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
